// File: rtl/riscv_dport_pkg.sv
// Shared definitions for the LSU data-port to AXI4-Lite bridge.
package riscv_dport_pkg;

    localparam int unsigned TAG_W = 11;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Request class; only same-class requests may be in flight together.
    typedef enum logic [1:0] {
        CLS_READ  = 2'd0,
        CLS_WRITE = 2'd1,
        CLS_LOCAL = 2'd2
    } req_class_e;

    // One order-FIFO entry: response tag plus the class that will retire it.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        req_class_e       cls;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = TAG_W + 2;

    // Decode the request strobes into a class. LOCAL beats WRITE beats READ
    // when the LSU raises more than one at once.
    function automatic req_class_e classify(
        input logic       rd,
        input logic [3:0] wr,
        input logic       inval,
        input logic       flush
    );
        req_class_e cls;
        cls = CLS_READ;
        if (inval || flush) begin
            cls = CLS_LOCAL;
        end else if (|wr) begin
            cls = CLS_WRITE;
        end else if (rd) begin
            cls = CLS_READ;
        end
        return cls;
    endfunction

endpackage

// File: rtl/riscv_dport_tag_fifo.sv
// Small synchronous FIFO holding the order of outstanding requests.
// Depth must be a power of two so the pointers wrap naturally.
module riscv_dport_tag_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 13,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push into a full FIFO is legal only
    // when the head leaves in the same cycle.
    always_comb begin
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/riscv_dport_axi.sv
// LSU data port to AXI4-Lite bridge. Single-beat requests are issued on the
// AR or AW/W channels; responses come back in request order because only
// requests of one class are ever in flight together.
module riscv_dport_axi
    import riscv_dport_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_data_wr_i,
    input  logic             mem_rd_i,
    input  logic [3:0]       mem_wr_i,
    input  logic             mem_cacheable_i,
    input  logic [TAG_W-1:0] mem_req_tag_i,
    input  logic             mem_invalidate_i,
    input  logic             mem_flush_i,
    output logic             mem_accept_o,
    output logic             mem_ack_o,
    output logic             mem_error_o,
    output logic [31:0]      mem_data_rd_o,
    output logic [TAG_W-1:0] mem_resp_tag_o,

    output logic             axi_awvalid_o,
    input  logic             axi_awready_i,
    output logic [31:0]      axi_awaddr_o,
    output logic             axi_wvalid_o,
    input  logic             axi_wready_i,
    output logic [31:0]      axi_wdata_o,
    output logic [3:0]       axi_wstrb_o,
    input  logic             axi_bvalid_i,
    input  logic [1:0]       axi_bresp_i,
    output logic             axi_bready_o,
    output logic             axi_arvalid_o,
    input  logic             axi_arready_i,
    output logic [31:0]      axi_araddr_o,
    input  logic             axi_rvalid_i,
    input  logic [31:0]      axi_rdata_i,
    input  logic [1:0]       axi_rresp_i,
    output logic             axi_rready_o
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    // Cacheability has no meaning without a cache.
    logic unused_cacheable;
    assign unused_cacheable = mem_cacheable_i;

    // Order FIFO.
    fifo_entry_t      push_entry;
    fifo_entry_t      head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] unused_fifo_count;

    // Request decode.
    req_class_e       new_cls;
    req_class_e       head_cls;
    logic             req_present;
    logic             ar_free;
    logic             aw_free;
    logic             chan_ok;
    logic             accept;
    logic             local_bypass;

    // Registered AXI request channels.
    logic             arvalid_q, arvalid_d;
    logic [31:0]      araddr_q,  araddr_d;
    logic             awvalid_q, awvalid_d;
    logic [31:0]      awaddr_q,  awaddr_d;
    logic             wvalid_q,  wvalid_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic [3:0]       wstrb_q,   wstrb_d;

    // Registered LSU response.
    logic             ack_q,   ack_d;
    logic             error_q, error_d;
    logic [31:0]      data_q,  data_d;
    logic [TAG_W-1:0] tag_q,   tag_d;

    riscv_dport_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (ENTRY_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head_bits),
        .count_o (unused_fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_entry = fifo_entry_t'(head_bits);
    assign head_cls   = head_entry.cls;

    // Decide which head entry retires this cycle.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            case (head_cls)
                CLS_READ:  fifo_pop = axi_rvalid_i;
                CLS_WRITE: fifo_pop = axi_bvalid_i;
                CLS_LOCAL: fifo_pop = 1'b1;
                default:   fifo_pop = 1'b0;
            endcase
        end
    end

    // Accept decision: a slot must be free (or freed by this cycle's pop),
    // the class must match what is already in flight, and the target
    // channel holding register must be free or draining now.
    always_comb begin
        req_present = mem_rd_i || (|mem_wr_i) || mem_invalidate_i || mem_flush_i;
        new_cls     = classify(mem_rd_i, mem_wr_i, mem_invalidate_i, mem_flush_i);
        ar_free     = !arvalid_q || axi_arready_i;
        aw_free     = (!awvalid_q || axi_awready_i) && (!wvalid_q || axi_wready_i);
        case (new_cls)
            CLS_READ:  chan_ok = ar_free;
            CLS_WRITE: chan_ok = aw_free;
            default:   chan_ok = 1'b1;
        endcase
        accept = req_present
              && (!fifo_full || fifo_pop)
              && (fifo_empty || (new_cls == head_cls))
              && chan_ok;
        // A maintenance request into an idle bridge is answered straight
        // away instead of taking a trip through the FIFO.
        local_bypass   = accept && (new_cls == CLS_LOCAL) && fifo_empty;
        fifo_push      = accept && !local_bypass;
        push_entry.tag = mem_req_tag_i;
        push_entry.cls = new_cls;
    end

    assign mem_accept_o = accept;

    // AXI request holding registers: load on accept, clear on handshake.
    always_comb begin
        arvalid_d = arvalid_q && !axi_arready_i;
        araddr_d  = araddr_q;
        awvalid_d = awvalid_q && !axi_awready_i;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q && !axi_wready_i;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (accept && (new_cls == CLS_READ)) begin
            arvalid_d = 1'b1;
            araddr_d  = mem_addr_i;
        end
        if (accept && (new_cls == CLS_WRITE)) begin
            awvalid_d = 1'b1;
            awaddr_d  = mem_addr_i;
            wvalid_d  = 1'b1;
            wdata_d   = mem_data_wr_i;
            wstrb_d   = mem_wr_i;
        end
    end

    // Response register: one ack per cycle, from the FIFO head or bypass.
    always_comb begin
        ack_d   = 1'b0;
        error_d = error_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (fifo_pop) begin
            ack_d = 1'b1;
            tag_d = head_entry.tag;
            case (head_cls)
                CLS_READ: begin
                    data_d  = axi_rdata_i;
                    error_d = (axi_rresp_i != AXI_RESP_OKAY);
                end
                CLS_WRITE: begin
                    data_d  = '0;
                    error_d = (axi_bresp_i != AXI_RESP_OKAY);
                end
                default: begin
                    data_d  = '0;
                    error_d = 1'b0;
                end
            endcase
        end else if (local_bypass) begin
            ack_d   = 1'b1;
            tag_d   = mem_req_tag_i;
            data_d  = '0;
            error_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ack_q     <= 1'b0;
            error_q   <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            ack_q     <= ack_d;
            error_q   <= error_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
        end
    end

    assign axi_arvalid_o  = arvalid_q;
    assign axi_araddr_o   = araddr_q;
    assign axi_awvalid_o  = awvalid_q;
    assign axi_awaddr_o   = awaddr_q;
    assign axi_wvalid_o   = wvalid_q;
    assign axi_wdata_o    = wdata_q;
    assign axi_wstrb_o    = wstrb_q;
    assign axi_rready_o   = 1'b1;
    assign axi_bready_o   = 1'b1;

    assign mem_ack_o      = ack_q;
    assign mem_error_o    = error_q;
    assign mem_data_rd_o  = data_q;
    assign mem_resp_tag_o = tag_q;

endmodule
